// File: rtl/ring_router_pkg.sv
// ring_router_pkg -- shared constants, route type and routing helpers for the
// parametrised three-port ring router.
//   PORT_L/PORT_E/PORT_W : port indices (local, east, west), NUM_PORTS = 3
//   route_e              : routing result; encodings equal the output port index
//   ring_route()         : shortest-path output for a destination on an n-node ring
//   inc3()               : +1 modulo 3, used for round-robin pointers
package ring_router_pkg;

  localparam int PORT_L    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_W    = 2;
  localparam int NUM_PORTS = 3;

  typedef enum logic [1:0] {
    RT_L = 2'(PORT_L),
    RT_E = 2'(PORT_E),
    RT_W = 2'(PORT_W)
  } route_e;

  // Arguments are zero-extended by the caller, so any ADDR_W up to 16 works.
  // Destinations outside the ring fall into the local port as an error sink.
  function automatic route_e ring_route(input logic [15:0] dest,
                                        input logic [15:0] node_id,
                                        input logic [16:0] n);
    logic [17:0] d;
    if ({1'b0, dest} >= n) return RT_L;
    // dest, node_id < n, so one conditional subtract replaces the modulo
    d = {2'b00, dest} + {1'b0, n} - {2'b00, node_id};
    if (d >= {1'b0, n}) d = d - {1'b0, n};
    if (d == '0) return RT_L;
    if (d <= {2'b00, n[16:1]}) return RT_E;  // even-n tie goes east
    return RT_W;
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

endpackage

// File: rtl/ring_router_param_if.sv
// ring_router_param_if -- per-port valid/ready bundle of the ring router.
//   in_data/in_valid/in_ready    : ingress, index 0 = local, 1 = east, 2 = west
//   out_data/out_valid/out_ready : egress, same indexing
//   modport slave  : the router side
//   modport master : the traffic source/sink side
interface ring_router_param_if
  import ring_router_pkg::*;
#(
  parameter int DATA_W = 64
);
  logic [NUM_PORTS-1:0][DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]             in_valid;
  logic [NUM_PORTS-1:0]             in_ready;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]             out_valid;
  logic [NUM_PORTS-1:0]             out_ready;

  modport slave  (input  in_data, in_valid, output in_ready,
                  output out_data, out_valid, input out_ready);
  modport master (output in_data, in_valid, input  in_ready,
                  input  out_data, out_valid, output out_ready);
endinterface

// File: rtl/ring_router_fifo.sv
// ring_router_fifo -- synchronous FIFO for one router input.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push_i/din_i : write; caller only pushes when count_o < FIFO_DEPTH
//   pop_i        : drop head; caller only pops when !empty_o
//   dout_o       : current head (valid when !empty_o)
//   empty_o, count_o : occupancy
module ring_router_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/ring_router_param.sv
// ring_router_param -- three-port (local/east/west) ring NoC router.
// Input FIFOs, shortest-path routing on a ring of run-time size, per-output
// round-robin arbitration and a registered output stage with backpressure.
//   clk, rst  : clock, async active-low reset (drops all buffered flits)
//   node_id   : this node's address, static after reset
//   ring_size : node count n (2..2^ADDR_W), static after reset
//   bus       : ring_router_param_if.slave, in_*/out_* per port
//   stat_cnt  : 3x16-bit saturating output transfer counters, only when
//               RING_ROUTER_STATS_EN is defined
// Flit layout: [ADDR_W-1:0] source, [2*ADDR_W-1:ADDR_W] destination.
module ring_router_param
  import ring_router_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] node_id,
  input  logic [ADDR_W:0]   ring_size,
  ring_router_param_if.slave bus
`ifdef RING_ROUTER_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0] stat_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_PORTS-1:0][DATA_W-1:0] head;
  logic [NUM_PORTS-1:0][CW-1:0]     cnt;
  logic [NUM_PORTS-1:0]             empty, push, pop, in_rdy;
  logic [NUM_PORTS-1:0][1:0]        rt;

  logic                             rdy_q;
  logic [NUM_PORTS-1:0][1:0]        ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]             ov_q, ov_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] od_q, od_d;

  logic [NUM_PORTS-1:0]             gnt_vld, fire;
  logic [NUM_PORTS-1:0][1:0]        gnt_idx;
  logic [1:0]                       idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    ring_router_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst),
      .push_i (push[p]),
      .din_i  (bus.in_data[p]),
      .pop_i  (pop[p]),
      .dout_o (head[p]),
      .empty_o(empty[p]),
      .count_o(cnt[p])
    );
  end

  // rdy_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_rdy[p] = rdy_q && (cnt[p] < CW'(FIFO_DEPTH));
      push[p]   = bus.in_valid[p] && in_rdy[p];
      rt[p]     = ring_route(16'(head[p][2*ADDR_W-1:ADDR_W]), 16'(node_id),
                             17'(ring_size));
    end
  end

  // Per-output round-robin; a grant only fires if the output register can
  // take the flit, and only a firing grant moves the pointer.
  always_comb begin
    ptr_d   = ptr_q;
    ov_d    = ov_q;
    od_d    = od_q;
    pop     = '0;
    gnt_vld = '0;
    gnt_idx = '0;
    fire    = '0;
    idx     = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      idx = ptr_q[o];
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!gnt_vld[o] && !empty[idx] && rt[idx] == 2'(o)) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx;
        end
        idx = inc3(idx);
      end
      fire[o] = gnt_vld[o] && (!ov_q[o] || bus.out_ready[o]);
      if (fire[o]) begin
        ov_d[o]          = 1'b1;
        od_d[o]          = head[gnt_idx[o]];
        ptr_d[o]         = inc3(gnt_idx[o]);
        pop[gnt_idx[o]]  = 1'b1;
      end else if (bus.out_ready[o]) begin
        ov_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      ptr_q <= '0;
      ov_q  <= '0;
      od_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      ptr_q <= ptr_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;

`ifdef RING_ROUTER_STATS_EN
  logic [NUM_PORTS-1:0][15:0] stat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (ov_q[o] && bus.out_ready[o] && stat_q[o] != 16'hFFFF)
          stat_q[o] <= stat_q[o] + 16'd1;
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_ring_router_param.sv
// tb_ring_router_param -- randomized and directed bench for ring_router_param
// with a queue-based reference model and a per-cycle compare process.
// Also exercises the RING_ROUTER_STATS_EN counters when that macro is defined.
module tb_ring_router_param;
  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] node_id = 4'd2;
  logic [AW:0]   ring_size = 5'd8;
`ifdef RING_ROUTER_STATS_EN
  logic [47:0]   stat_cnt;
`endif

  ring_router_param_if #(.DATA_W(DW)) bus ();

  ring_router_param #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .node_id  (node_id),
    .ring_size(ring_size),
    .bus      (bus)
`ifdef RING_ROUTER_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input int src, input int dst, input logic [31:0] tag);
    logic [63:0] f;
    f = '0;
    f[3:0]   = src[3:0];
    f[7:4]   = dst[3:0];
    f[63:32] = tag;
    return f;
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] mq [3][$];
  bit          m_ov  [3] = '{0, 0, 0};
  logic [63:0] m_od  [3] = '{64'd0, 64'd0, 64'd0};
  int          m_ptr [3] = '{0, 0, 0};
  int          m_cnt [3] = '{0, 0, 0};
  bit          m_rdy = 0;

  // Shortest path by plain integer arithmetic: 0 local, 1 east, 2 west.
  function automatic int mroute(input logic [63:0] f);
    int dest, n, d;
    dest = int'(f[7:4]);
    n    = int'(ring_size);
    if (dest >= n) return 0;
    d = ((dest - int'(node_id)) % n + n) % n;
    if (d == 0) return 0;
    if (d <= n / 2) return 1;
    return 2;
  endfunction

  initial begin : model
    int g [3];
    int sz[3];
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int p = 0; p < 3; p++) begin
          mq[p].delete();
          m_ov[p] = 0; m_od[p] = '0; m_ptr[p] = 0; m_cnt[p] = 0;
        end
        m_rdy = 0;
      end else begin
        for (int p = 0; p < 3; p++) sz[p] = mq[p].size();
        for (int o = 0; o < 3; o++) begin
          g[o] = -1;
          for (int k = 0; k < 3; k++) begin
            int p;
            p = (m_ptr[o] + k) % 3;
            if (g[o] < 0 && sz[p] > 0 && mroute(mq[p][0]) == o) g[o] = p;
          end
        end
        for (int o = 0; o < 3; o++) begin
          if (m_ov[o] && bus.out_ready[o] && m_cnt[o] < 65535) m_cnt[o]++;
          if (g[o] >= 0 && (!m_ov[o] || bus.out_ready[o])) begin
            m_od[o]  = mq[g[o]].pop_front();
            m_ov[o]  = 1;
            m_ptr[o] = (g[o] + 1) % 3;
          end else if (bus.out_ready[o]) begin
            m_ov[o] = 0;
          end
        end
        for (int p = 0; p < 3; p++)
          if (bus.in_valid[p] && m_rdy && sz[p] < DEP) mq[p].push_back(bus.in_data[p]);
        m_rdy = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [2:0] er, ev;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        er[p] = m_rdy && (mq[p].size() < DEP);
        ev[p] = m_ov[p];
      end
      chk("in_ready", 64'(bus.in_ready), 64'(er));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      for (int o = 0; o < 3; o++)
        if (m_ov[o]) chk("out_data", bus.out_data[o], m_od[o]);
`ifdef RING_ROUTER_STATS_EN
      chk("stat_cnt", 64'(stat_cnt),
          {16'd0, 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Entered and left at a falling edge; checks reset values asynchronously.
  task automatic do_reset(input int n, input int nid);
    bus.in_valid = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_data0", bus.out_data[0], 64'd0);
    ring_size = 5'(n);
    node_id   = 4'(nid);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rel_in_ready", 64'(bus.in_ready), 64'h7);
  endtask

  task automatic rand_run(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      for (int p = 0; p < 3; p++) begin
        bus.in_valid[p]  = ($urandom % 2) == 0;
        bus.in_data[p]   = mk(p, int'($urandom_range(0, 9)), $urandom);
        bus.out_ready[p] = ($urandom % 4) != 0;
      end
      step();
    end
    bus.in_valid  = '0;
    bus.out_ready = 3'b111;
    repeat (40) step();
  endtask

  initial begin : stim
    int acc;
    int dsw[5];
    int esw[5];
    dsw = '{5, 6, 7, 1, 9};
    esw = '{1, 1, 2, 2, 0};
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 3'b111;
    step();
    chk("init_out_valid", 64'(bus.out_valid), 64'd0);
    chk("init_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("first_in_ready", 64'(bus.in_ready), 64'h7);

    // single local flit to self: 2-edge latency
    bus.in_valid = 3'b001;
    bus.in_data[0] = mk(0, 2, 32'hA5);
    step();
    bus.in_valid = '0;
    chk("lat_edge0", 64'(bus.out_valid), 64'd0);
    step();
    chk("lat_edge1", 64'(bus.out_valid), 64'b001);
    chk("lat_data", bus.out_data[0], mk(0, 2, 32'hA5));

    // destination sweep
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 3'b001;
      bus.in_data[0] = mk(0, dsw[i], 32'(i));
      step();
      bus.in_valid = '0;
      step();
      chk("sweep_port", 64'(bus.out_valid), 64'(1 << esw[i]));
    end

    // three-way contention on the east output
    do_reset(8, 2);
    bus.in_valid = 3'b111;
    for (int p = 0; p < 3; p++) bus.in_data[p] = mk(p, 4, 32'(10 + p));
    step();
    bus.in_valid = '0;
    for (int p = 0; p < 3; p++) begin
      step();
      chk("rr_valid", 64'(bus.out_valid[1]), 64'd1);
      chk("rr_order", 64'(bus.out_data[1][63:32]), 64'(10 + p));
    end
    bus.in_valid = 3'b111;
    for (int p = 0; p < 3; p++) bus.in_data[p] = mk(p, 4, 32'(20 + p));
    step();
    bus.in_valid = '0;
    step();
    chk("rr_restart_L", 64'(bus.out_data[1][63:32]), 64'd20);
    repeat (4) step();

    // backpressure on east output
    do_reset(8, 2);
    bus.out_ready = 3'b101;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.in_ready[1]) break;
      bus.in_valid = 3'b010;
      bus.in_data[1] = mk(1, 4, 32'(100 + i));
      acc++;
      step();
    end
    bus.in_valid = '0;
    chk("bp_accepts", 64'(acc), 64'd9);
    chk("bp_full", 64'(bus.in_ready[1]), 64'd0);
    for (int j = 0; j < 9; j++) begin
      chk("bp_valid", 64'(bus.out_valid[1]), 64'd1);
      chk("bp_order", 64'(bus.out_data[1][63:32]), 64'(100 + j));
      bus.out_ready[1] = 1'b1;
      step();
      if (j == 0) chk("bp_ready_rise", 64'(bus.in_ready[1]), 64'd1);
    end
    chk("bp_drained", 64'(bus.out_valid[1]), 64'd0);

    // reset mid-traffic
    bus.out_ready = 3'b000;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 3'b001;
      bus.in_data[0] = mk(0, 4, 32'(200 + i));
      step();
    end
    bus.in_valid = '0;
    chk("mid_buffered", 64'(bus.out_valid[1]), 64'd1);
    do_reset(8, 2);
    bus.out_ready = 3'b111;
    repeat (4) begin
      step();
      chk("mid_no_stale", 64'(bus.out_valid), 64'd0);
    end

    // randomized traffic, even ring then odd ring
    rand_run(3000);
    do_reset(5, 3);
    rand_run(3000);

`ifdef RING_ROUTER_STATS_EN
    do_reset(8, 2);
    bus.out_ready = 3'b111;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 3'b001;
      bus.in_data[0] = mk(0, (i < 3) ? 2 : 4, 32'(i));
      step();
    end
    bus.in_valid = '0;
    repeat (4) step();
    chk("stat_small", 64'(stat_cnt), 64'h0000_0002_0003);
    bus.in_valid = 3'b001;
    bus.in_data[0] = mk(0, 2, 32'hFEED);
    repeat (70000) step();
    bus.in_valid = '0;
    repeat (3) step();
    chk("stat_sat", 64'(stat_cnt[15:0]), 64'hFFFF);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
